// File: rtl/gpca_pipe.sv
// gpca_pipe: pipelined non-restoring divider / square-root array.
// One add/subtract row per stage, N stages, stage register after every row.
// Optional macro GPCA_REM_CORRECT_EN: when defined, the last row applies the
// non-restoring remainder correction and out_r carries the remainder; when
// undefined, out_r is driven 0.
module gpca_pipe #(
    parameter int N    = 8,
    parameter int OP_W = 2 * N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [OP_W-1:0] in_a,
    input  logic [N-1:0]    in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_q,
    output logic [N:0]      out_r,
    output logic            out_dz,
    output logic            busy
);

    // Signed partial remainder width; the root rows shift by two, so keep
    // enough headroom that only the sign bit carries control information.
    localparam int RW = N + 5;

    // Stage registers; r_vld[N] is the output stage.
    logic [N:1]      r_vld;
    logic            r_mode [1:N-1];
    logic            r_dz   [1:N-1];
    logic            r_sat  [1:N-1];
    logic [RW-1:0]   r_rem  [1:N-1];
    logic [N-1:0]    r_q    [1:N-1];
    logic [OP_W-1:0] r_sh   [1:N-1];
    logic [N-1:0]    r_b    [1:N-1];

    logic [N-1:0]    r_out_q;
    logic [N:0]      r_out_r;
    logic            r_out_dz;

    // Row inputs (index k feeds row k) and row outputs.
    logic            w_mode_i [0:N-1];
    logic            w_dz_i   [0:N-1];
    logic            w_sat_i  [0:N-1];
    logic [RW-1:0]   w_rem_i  [0:N-1];
    logic [N-1:0]    w_q_i    [0:N-1];
    logic [OP_W-1:0] w_sh_i   [0:N-1];
    logic [N-1:0]    w_b_i    [0:N-1];
    logic [RW-1:0]   w_rem_o  [0:N-1];
    logic [N-1:0]    w_q_o    [0:N-1];
    logic [OP_W-1:0] w_sh_o   [0:N-1];

    logic            w_adv;
    logic [N-1:0]    w_q_fin;
    logic [N:0]      w_r_fin;

    assign w_adv     = ~(r_vld[N] & ~out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_vld[N];
    assign out_q     = r_out_q;
    assign out_r     = r_out_r;
    assign out_dz    = r_out_dz;
    assign busy      = |r_vld;

    // Row 0 takes the operands directly; later rows take the stage registers.
    // A quotient that would not fit N bits (including b = 0) is flagged up
    // front and overrides the array result at the output.
    always_comb begin
        w_mode_i[0] = in_mode;
        w_dz_i[0]   = ~in_mode & (in_b == '0);
        w_sat_i[0]  = ~in_mode & (in_a[OP_W-1:N] >= in_b);
        w_rem_i[0]  = in_mode ? '0 : RW'(in_a[OP_W-1:N]);
        w_sh_i[0]   = in_mode ? in_a : {in_a[N-1:0], {N{1'b0}}};
        w_q_i[0]    = '0;
        w_b_i[0]    = in_b;
        for (int unsigned k = 1; k < N; k++) begin
            w_mode_i[k] = r_mode[k];
            w_dz_i[k]   = r_dz[k];
            w_sat_i[k]  = r_sat[k];
            w_rem_i[k]  = r_rem[k];
            w_sh_i[k]   = r_sh[k];
            w_q_i[k]    = r_q[k];
            w_b_i[k]    = r_b[k];
        end
    end

    // Non-restoring rows: sign of the previous remainder picks add or subtract;
    // divide uses the divisor as B, root uses the partial root with 01 (after a
    // non-negative remainder) or 11 (after a negative one) appended.
    always_comb begin
        logic          w_neg;
        logic [RW-1:0] w_rsh;
        logic [RW-1:0] w_bop;
        w_neg = 1'b0;
        w_rsh = '0;
        w_bop = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_neg = w_rem_i[k][RW-1];
            if (w_mode_i[k]) begin
                w_rsh = {w_rem_i[k][RW-3:0], w_sh_i[k][OP_W-1 -: 2]};
                w_bop = RW'({w_q_i[k], w_neg, 1'b1});
            end else begin
                w_rsh = {w_rem_i[k][RW-2:0], w_sh_i[k][OP_W-1]};
                w_bop = RW'(w_b_i[k]);
            end
            w_rem_o[k] = w_neg ? (w_rsh + w_bop) : (w_rsh - w_bop);
            w_q_o[k]   = {w_q_i[k][N-2:0], ~w_rem_o[k][RW-1]};
            w_sh_o[k]  = w_mode_i[k] ? (w_sh_i[k] << 2) : (w_sh_i[k] << 1);
        end
    end

    // Final row result: saturation override and optional remainder correction.
    always_comb begin
        w_q_fin = w_sat_i[N-1] ? '1 : w_q_o[N-1];
`ifdef GPCA_REM_CORRECT_EN
        begin
            logic [N:0] w_fix_add;
            logic [N:0] w_rem_fix;
            // Only the low N+1 bits survive, so the correction add is done at that width.
            w_fix_add = w_mode_i[N-1] ? {w_q_o[N-1], 1'b1} : {1'b0, w_b_i[N-1]};
            w_rem_fix = w_rem_o[N-1][RW-1] ? (w_rem_o[N-1][N:0] + w_fix_add)
                                           : w_rem_o[N-1][N:0];
            w_r_fin   = w_sat_i[N-1] ? '0 : w_rem_fix;
        end
`else
        w_r_fin = '0;
`endif
    end

    // Valid chain and output registers; everything holds while the output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_out_q  <= '0;
            r_out_r  <= '0;
            r_out_dz <= 1'b0;
        end else if (w_adv) begin
            r_vld    <= {r_vld[N-1:1], in_valid};
            r_out_q  <= w_q_fin;
            r_out_r  <= w_r_fin;
            r_out_dz <= r_vld[N-1] & w_dz_i[N-1];
        end
    end

    // Intermediate datapath registers; no reset needed, qualified by r_vld.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int unsigned k = 1; k < N; k++) begin
                r_mode[k] <= w_mode_i[k-1];
                r_dz[k]   <= w_dz_i[k-1];
                r_sat[k]  <= w_sat_i[k-1];
                r_rem[k]  <= w_rem_o[k-1];
                r_q[k]    <= w_q_o[k-1];
                r_sh[k]   <= w_sh_o[k-1];
                r_b[k]    <= w_b_i[k-1];
            end
        end
    end

endmodule

// File: tb/tb_gpca_pipe.sv
// Self-checking bench for gpca_pipe (N = 8) using a result scoreboard.
module tb_gpca_pipe;

    localparam int N    = 8;
    localparam int OP_W = 2 * N;
`ifdef GPCA_REM_CORRECT_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_mode = 1'b0;
    logic [OP_W-1:0] in_a = '0;
    logic [N-1:0]    in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N-1:0]    out_q;
    logic [N:0]      out_r;
    logic            out_dz;
    logic            busy;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N:0]   r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    gpca_pipe #(.N(N), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [N:0] rexp(input int r);
        return REM_EN ? (N+1)'(r) : '0;
    endfunction

    // Reference model: integer divide with saturation / divide-by-zero, integer sqrt.
    function automatic exp_t model(input logic m, input logic [OP_W-1:0] a, input logic [N-1:0] b);
        exp_t e;
        longint unsigned qq;
        e.dz = 1'b0;
        e.q  = '0;
        e.r  = '0;
        if (m) begin
            qq = 0;
            for (longint unsigned x = 0; x < (1 << N); x++)
                if (x * x <= longint'(a)) qq = x;
            e.q = qq[N-1:0];
            e.r = REM_EN ? (N+1)'(longint'(a) - qq * qq) : '0;
        end else if (b == '0) begin
            e.q  = '1;
            e.dz = 1'b1;
        end else begin
            qq = longint'(a) / longint'(b);
            if (qq >= (1 << N)) begin
                e.q = '1;
            end else begin
                e.q = qq[N-1:0];
                e.r = REM_EN ? (N+1)'(longint'(a) % longint'(b)) : '0;
            end
        end
        return e;
    endfunction

    // One clock of stimulus: inputs set at the falling edge, handshakes read 1 time unit later.
    task automatic drive_cycle(input logic v, input logic m, input logic [OP_W-1:0] a,
                               input logic [N-1:0] b, input logic ordy,
                               output logic acc, output logic cons);
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        cons = out_valid & out_ready;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({out_valid, busy, out_dz, out_q, out_r} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%0b busy=%0b dz=%0b q=%0d r=%0d, want all 0",
                     out_valid, busy, out_dz, out_q, out_r);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divide();
        logic acc, cons;
        int   t_acc;
        bit   got;
        exp_t e;
        t_acc = 0;
        got   = 0;
        drive_cycle(1'b1, 1'b0, 16'd1000, 8'd7, 1'b1, acc, cons);
        n_vec++;
        if (acc !== 1'b1) begin
            n_bad++;
            $display("FAIL div_accept: got %0b want 1", acc);
        end
        if (acc) begin
            sb.push_back(exp_t'{8'd142, rexp(6), 1'b0});
            t_acc = cyc;
        end
        for (int c = 0; c < 3 * N && !got; c++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, cons);
            if (cons) begin
                got = 1;
                e = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                n_vec++;
                if ({out_q, out_r, out_dz} !== e) begin
                    n_bad++;
                    $display("FAIL div_1000_7: got q=%0d r=%0d dz=%0b, want q=%0d r=%0d dz=%0b",
                             out_q, out_r, out_dz, e.q, e.r, e.dz);
                end
                n_vec++;
                if (cyc - t_acc != N) begin
                    n_bad++;
                    $display("FAIL div_latency: got %0d cycles want %0d", cyc - t_acc, N);
                end
            end
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL div_timeout: got no result want 1 result");
        end
    endtask

    task automatic test_root();
        logic acc, cons;
        int   i;
        exp_t e;
        logic [OP_W-1:0] a_t [0:1];
        exp_t            x_t [0:1];
        a_t[0] = 16'd65535; x_t[0] = exp_t'{8'd255, rexp(510), 1'b0};
        a_t[1] = 16'd0;     x_t[1] = exp_t'{8'd0, rexp(0), 1'b0};
        i = 0;
        for (int c = 0; c < 3 * N && (i < 2 || sb.size() > 0); c++) begin
            drive_cycle(i < 2, 1'b1, (i < 2) ? a_t[i] : '0, 8'd99, 1'b1, acc, cons);
            if (c == 1) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL root_busy: got %0b want 1", busy);
                end
            end
            if (cons) begin
                e = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                n_vec++;
                if ({out_q, out_r, out_dz} !== e) begin
                    n_bad++;
                    $display("FAIL root: got q=%0d r=%0d dz=%0b, want q=%0d r=%0d dz=%0b",
                             out_q, out_r, out_dz, e.q, e.r, e.dz);
                end
            end
            if (acc) begin
                sb.push_back(x_t[i]);
                i++;
            end
        end
        n_vec++;
        if (i != 2 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL root_timeout: got accepted=%0d pending=%0d want 2/0", i, sb.size());
        end
    endtask

    task automatic test_dz_sat();
        logic acc, cons;
        int   i;
        exp_t e;
        logic [OP_W-1:0] a_t [0:3];
        logic [N-1:0]    b_t [0:3];
        exp_t            x_t [0:3];
        a_t[0] = 16'd300;   b_t[0] = 8'd0;   x_t[0] = exp_t'{8'd255, rexp(0), 1'b1};
        a_t[1] = 16'd65535; b_t[1] = 8'd1;   x_t[1] = exp_t'{8'd255, rexp(0), 1'b0};
        a_t[2] = 16'd65279; b_t[2] = 8'd255; x_t[2] = exp_t'{8'd255, rexp(254), 1'b0};
        a_t[3] = 16'd0;     b_t[3] = 8'd5;   x_t[3] = exp_t'{8'd0, rexp(0), 1'b0};
        i = 0;
        for (int c = 0; c < 4 * N && (i < 4 || sb.size() > 0); c++) begin
            drive_cycle(i < 4, 1'b0, (i < 4) ? a_t[i] : '0, (i < 4) ? b_t[i] : '0,
                        1'b1, acc, cons);
            if (cons) begin
                e = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                n_vec++;
                if ({out_q, out_r, out_dz} !== e) begin
                    n_bad++;
                    $display("FAIL dz_sat: got q=%0d r=%0d dz=%0b, want q=%0d r=%0d dz=%0b",
                             out_q, out_r, out_dz, e.q, e.r, e.dz);
                end
            end
            if (acc) begin
                sb.push_back(x_t[i]);
                i++;
            end
        end
        n_vec++;
        if (i != 4 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL dz_sat_timeout: got accepted=%0d pending=%0d want 4/0", i, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic acc, cons, ordy, stall;
        int   i;
        exp_t e;
        logic [N+N:0]    held;
        logic            m_t [0:19];
        logic [OP_W-1:0] a_t [0:19];
        logic [N-1:0]    b_t [0:19];
        for (int k = 0; k < 20; k++) begin
            m_t[k] = 1'($urandom_range(0, 1));
            b_t[k] = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
            if (m_t[k] || b_t[k] == '0 || $urandom_range(0, 3) == 0)
                a_t[k] = OP_W'($urandom);
            else
                a_t[k] = OP_W'($urandom_range(0, int'(b_t[k]) * 256 - 1));
        end
        i = 0;
        held = '0;
        for (int c = 0; c < 200 && (i < 20 || sb.size() > 0); c++) begin
            stall = (c >= 10 && c < 15);
            ordy  = !stall;
            drive_cycle(i < 20, (i < 20) ? m_t[i] : 1'b0, (i < 20) ? a_t[i] : '0,
                        (i < 20) ? b_t[i] : '0, ordy, acc, cons);
            n_vec++;
            if (in_ready !== !stall) begin
                n_bad++;
                $display("FAIL b2b_in_ready c=%0d: got %0b want %0b", c, in_ready, !stall);
            end
            if (stall) begin
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_stall_valid c=%0d: got %0b want 1", c, out_valid);
                end
            end
            if (c == 10) held = {out_q, out_r, out_dz};
            if (c > 10 && c <= 15) begin
                n_vec++;
                if ({out_q, out_r, out_dz} !== held) begin
                    n_bad++;
                    $display("FAIL b2b_hold c=%0d: got %h want %h", c, {out_q, out_r, out_dz}, held);
                end
            end
            if (cons) begin
                e = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                n_vec++;
                if ({out_q, out_r, out_dz} !== e) begin
                    n_bad++;
                    $display("FAIL b2b_result c=%0d: got q=%0d r=%0d dz=%0b, want q=%0d r=%0d dz=%0b",
                             c, out_q, out_r, out_dz, e.q, e.r, e.dz);
                end
            end
            if (acc) begin
                sb.push_back(model(m_t[i], a_t[i], b_t[i]));
                i++;
            end
        end
        n_vec++;
        if (i != 20 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_timeout: got accepted=%0d pending=%0d want 20/0", i, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, cons;
        int   seen;
        for (int k = 0; k < 4; k++)
            drive_cycle(1'b1, 1'(k % 2), OP_W'(1000 + k), 8'd7, 1'b1, acc, cons);
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, cons);
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midflight_pre: got busy=%0b valid=%0b want busy=1 valid=0", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midflight_reset: got valid=%0b busy=%0b in_ready=%0b want 0/0/1",
                     out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        seen = 0;
        for (int c = 0; c < 2 * N; c++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, cons);
            if (out_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midflight_stale: got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_root();
        test_dz_sat();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
